mux_rr_arbiter: RTL
===================

// Module: mux_rr_arbiter
// PURPOSE
//   Round-robin arbiter sharing one W-bit output channel among N requesters via valid/ready.
//   Selects a winner and drives the 4:1 key-mux select (out_sel) plus one registered output stage.
//   Sits in front of the mux42 datapath: sequences which a[i] reaches y and holds data until the consumer accepts it.
// PARAMETERS
//   N        4  number of requesters; power of two, >=2
//   W        2  data width per requester
//   SEL_W    2  select width; must equal clog2(N)
//   MAX_HOLD 4  max consecutive grants to one requester (used only with MUX_ARB_HOLD_EN)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   req_valid  in   N      requester i has data
//   req_data   in   N*W    flat; requester i at [i*W +: W]
//   req_ready  out  N      one-hot accept; a beat transfers on req_valid[i]&req_ready[i]
//   out_valid  out  1      output register holds a beat
//   out_data   out  W      registered winning data
//   out_sel    out  SEL_W  index of the requester that produced out_data
//   out_ready  in   1      consumer accepts; a beat transfers on out_valid&out_ready
//   busy       out  1      state==SEND
// BEHAVIOUR
//   Reset (async): out_valid=0, out_data=0, out_sel=0, ptr=0, state=IDLE; req_ready=0 while rst_n low.
//   FSM: IDLE (output register empty), SEND (output register full).
//   can_load = (state==IDLE) | out_ready. Combinational req_ready: one-hot winner when can_load & |req_valid, else 0.
//   Winner: first i with req_valid[i], scanning ptr, ptr+1, ... mod N (wrap at N-1 -> 0).
//   On a load: out_data<=req_data[win], out_sel<=win, out_valid<=1, state<=SEND, ptr<=(win+1) mod N.
//   SEND & out_ready & no valid req: out_valid<=0, state<=IDLE. SEND & !out_ready: hold all; req_ready=0.
//   Simultaneous drain+load in SEND: new beat replaces the old in the same edge; full throughput, 1 beat/cycle.
//   Latency: req accepted cycle t -> out_valid at t+1. No combinational valid->valid path; out_ready->req_ready is comb.
//   Fairness: with all N requesting continuously, grants cycle 0,1,..,N-1,0 (each within N beats).
//   ptr updates only on a load; idle cycles and stalls never move it.
//   Requester dropping valid without handshake: legal, no effect. Data is sampled only on a load.
//   Reset mid-SEND discards the held beat; first grant after reset goes to lowest valid index from 0.
// CONFIGURATION
//   MUX_ARB_HOLD_EN defined: on a load for win==previous winner still valid, hold counter increments;
//     ptr stays at win while hold_cnt < MAX_HOLD-1, then ptr<=(win+1) mod N and hold_cnt<=0.
//     Winner change or idle clears hold_cnt. Reset: hold_cnt=0.
//   Undefined: pure round-robin, ptr advances after every grant; no hold counter or MAX_HOLD logic.
// STRUCTURE
//   Package mux_arb_pkg: state encoding localparams (ST_IDLE=1'b0, ST_SEND=1'b1), default N/W,
//     function rr_pick(valid, ptr) returning winner index + found flag.
//   One sub-module: rr_prio_pick (combinational rotate/priority-encode/unrotate of req_valid from ptr);
//     top keeps FSM, ptr, output register, optional hold counter.
// TESTING
//   Reset: rst_n=0 with req_valid=4'b1111 -> req_ready=0, out_valid=0, out_sel=0; release -> first grant idx 0.
//   All valid, out_ready=1, data i=2'(i) -> out_sel 0,1,2,3,0 on consecutive cycles, out_data matches, 1 beat/cycle.
//   Only req 2 valid (data 2'b10), out_ready=0 for 3 cycles -> out_valid held, out_data=2'b10, req_ready=0; release -> drains.
//   ptr=3 wrap: after grant to 2, req_valid=4'b1001 -> grant 3, then 0, then 3.
//   Async reset asserted mid-SEND, between clock edges -> out_valid drops at once; held beat never seen at output.
//   MUX_ARB_HOLD_EN, MAX_HOLD=4, all valid -> out_sel 0,0,0,0,1,1,1,1,2...; undefined -> 0,1,2,3.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin output arbiter: FSM encoding, default sizes
// and a reference round-robin pick function for the default requester count.
package mux_arb_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SEND = 1'b1;

    localparam int DEF_N     = 4;
    localparam int DEF_W     = 2;
    localparam int DEF_SEL_W = $clog2(DEF_N);

    typedef struct packed {
        logic                 found;
        logic [DEF_SEL_W-1:0] idx;
    } pick_t;

    // Scan downward so the smallest offset from ptr is the one left standing.
    function automatic pick_t rr_pick(input logic [DEF_N-1:0] valid,
                                      input logic [DEF_SEL_W-1:0] ptr);
        pick_t                p;
        logic [DEF_SEL_W-1:0] idx;
        p = '0;
        for (int k = DEF_N - 1; k >= 0; k--) begin
            idx = ptr + DEF_SEL_W'(k);
            if (valid[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational round-robin winner select: rotate the request vector so ptr sits at
// bit 0, priority-encode the lowest set bit, then rotate the index back.
module rr_prio_pick #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] win,
    output logic             found
);

    logic [N-1:0]     rot;
    logic [SEL_W-1:0] off;
    logic [SEL_W-1:0] idx;

    always_comb begin
        rot = '0;
        idx = '0;
        for (int k = 0; k < N; k++) begin
            idx    = ptr + SEL_W'(k);
            rot[k] = valid[idx];
        end
    end

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = SEL_W'(k);
            end
        end
    end

    assign win = ptr + off;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the mux42 select with a one-deep registered output stage.
// Optional MUX_ARB_HOLD_EN lets a requester keep the grant for up to MAX_HOLD beats.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int W        = DEF_W,
    parameter int SEL_W    = $clog2(N),
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_data,
    output logic [N-1:0]     req_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_sel,
    input  logic             out_ready,
    output logic             busy
);

    if (SEL_W != $clog2(N) || MAX_HOLD < 1) begin : g_bad_cfg
        $error("mux_rr_arbiter: SEL_W must equal clog2(N) and MAX_HOLD must be >= 1");
    end

    logic             state;
    logic             state_next;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] win;
    logic             found;
    logic             can_load;
    logic             load;

    rr_prio_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .win   (win),
        .found (found)
    );

    // Gating with rst_n keeps req_ready low for the whole time reset is held.
    assign can_load = (state == ST_IDLE) | out_ready;
    assign load     = rst_n & can_load & found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (load) state_next = ST_SEND;
            ST_SEND: begin
                if (load)           state_next = ST_SEND;
                else if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (load) req_ready[win] = 1'b1;
        out_valid = (state == ST_SEND);
        busy      = (state == ST_SEND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_sel  <= '0;
        end else if (load) begin
            out_data <= req_data[win*W +: W];
            out_sel  <= win;
        end
    end

`ifdef MUX_ARB_HOLD_EN
    localparam int HC_W = $clog2(MAX_HOLD) + 1;

    logic [HC_W-1:0] hold_cnt;
    logic [HC_W-1:0] run;

    // A different winner starts a fresh streak; out_sel is the previous winner.
    assign run = (win == out_sel) ? hold_cnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            hold_cnt <= '0;
        end else if (load) begin
            if (run < HC_W'(MAX_HOLD - 1)) begin
                ptr      <= win;
                hold_cnt <= run + 1'b1;
            end else begin
                ptr      <= win + 1'b1;
                hold_cnt <= '0;
            end
        end else if (state == ST_IDLE) begin
            hold_cnt <= '0;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ptr <= '0;
        else if (load) ptr <= win + 1'b1;
    end
`endif

endmodule
